// File: rtl/asrv32_tm_pkg.sv
// asrv32_tm_pkg: shared encodings for the asrv32 end-of-test monitor.
//   - monitor state, termination cause and verdict codes
//   - the ebreak encoding and the riscv-tests exit magic held in x17
//   - trace entry widths for the register-file and data-memory channels
package asrv32_tm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
    localparam logic [1:0] CAUSE_LIMIT   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [1:0] VERDICT_UNKNOWN = 2'd0;
    localparam logic [1:0] VERDICT_PASS    = 2'd1;
    localparam logic [1:0] VERDICT_FAIL    = 2'd2;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [31:0] EXIT_MAGIC  = 32'h0000_005d;

    localparam int unsigned RF_TRACE_W  = 37;
    localparam int unsigned MEM_TRACE_W = 68;

    // riscv-tests exit protocol: x17 holds the magic, x10 is zero on success.
    function automatic logic [1:0] exit_verdict(input logic [31:0] x17, input logic [31:0] x10);
        if (x17 != EXIT_MAGIC) begin
            return VERDICT_UNKNOWN;
        end
        return (x10 == 32'd0) ? VERDICT_PASS : VERDICT_FAIL;
    endfunction

endpackage

// File: rtl/asrv32_trace_fifo.sv
// asrv32_trace_fifo: first-word-fall-through trace buffer.
//   push/din     : enqueue din (dropped and overflow set when full without a pop)
//   pop          : dequeue the head (ignored when empty)
//   dout/valid   : head entry, zero when empty
//   full         : all DEPTH entries occupied
//   overflow     : sticky, an entry was dropped since reset
module asrv32_trace_fifo
    import asrv32_tm_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             overflow_q;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign valid    = !empty;
    assign dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

endmodule

// File: rtl/asrv32_test_monitor.sv
// asrv32_test_monitor: end-of-test detector and write tracer for the asrv32 SoC.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_run                      : IDLE -> RUN when high
//   i_inst/i_inst_valid/i_iaddr: retiring instruction probe
//   i_rf_*                     : base-register write probe
//   i_mem_*                    : data-memory write probe
//   i_rf_pop/i_mem_pop         : drain the trace FIFOs
//   o_*_trace*, o_*_overflow   : trace FIFO heads, valids and sticky drop flags
//   o_state/o_done/o_cause     : monitor state and termination cause
//   o_verdict/o_exit_code      : riscv-tests result from shadow x17/x10
//   o_cycle_count/o_retired_count : RUN cycles and retired instructions
module asrv32_test_monitor
    import asrv32_tm_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH   = 2000,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_run,
    input  logic [31:0]            i_inst,
    input  logic                   i_inst_valid,
    input  logic [31:0]            i_iaddr,
    input  logic                   i_rf_wr_en,
    input  logic [4:0]             i_rf_rd_addr,
    input  logic [31:0]            i_rf_rd_data,
    input  logic                   i_mem_wr_en,
    input  logic [31:0]            i_mem_addr,
    input  logic [31:0]            i_mem_data,
    input  logic [3:0]             i_mem_mask,
    input  logic                   i_rf_pop,
    input  logic                   i_mem_pop,
    output logic                   o_rf_trace_valid,
    output logic                   o_mem_trace_valid,
    output logic [RF_TRACE_W-1:0]  o_rf_trace,
    output logic [MEM_TRACE_W-1:0] o_mem_trace,
    output logic                   o_rf_overflow,
    output logic                   o_mem_overflow,
    output logic [1:0]             o_state,
    output logic                   o_done,
    output logic [1:0]             o_cause,
    output logic [1:0]             o_verdict,
    output logic [31:0]            o_exit_code,
    output logic [CNT_W-1:0]       o_cycle_count,
    output logic [CNT_W-1:0]       o_retired_count
);

    localparam logic [31:0]      ADDR_LIMIT   = 32'(MEMORY_DEPTH - 4);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [1:0]       verdict_q, verdict_d;
    logic [31:0]      x10_q, x10_d;
    logic [31:0]      x17_q, x17_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic in_run;
    logic rf_push;
    logic mem_push;
    logic is_ebreak;
    logic is_limit;
    logic is_timeout;
    logic unused_rf_full;
    logic unused_mem_full;

    always_comb begin
        in_run     = (state_q == ST_RUN);
        rf_push    = in_run && i_rf_wr_en && (i_rf_rd_addr != 5'd0);
        mem_push   = in_run && i_mem_wr_en;
        is_ebreak  = i_inst_valid && (i_inst == EBREAK_INST);
        is_limit   = i_inst_valid && (i_iaddr >= ADDR_LIMIT);
        is_timeout = (TIMEOUT_CYCLES != 0) && (cycle_q == TIMEOUT_LAST);

        state_d   = state_q;
        cause_d   = cause_q;
        verdict_d = verdict_q;
        x10_d     = x10_q;
        x17_d     = x17_q;
        cycle_d   = cycle_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + 1'b1;
                end
                if (i_inst_valid && (retired_q != '1)) begin
                    retired_d = retired_q + 1'b1;
                end
                if (i_rf_wr_en && (i_rf_rd_addr == 5'd10)) begin
                    x10_d = i_rf_rd_data;
                end
                if (i_rf_wr_en && (i_rf_rd_addr == 5'd17)) begin
                    x17_d = i_rf_rd_data;
                end
                if (is_ebreak || is_limit || is_timeout) begin
                    state_d = ST_DONE;
                    if (is_ebreak) begin
                        cause_d = CAUSE_EBREAK;
                    end else if (is_limit) begin
                        cause_d = CAUSE_LIMIT;
                    end else begin
                        cause_d = CAUSE_TIMEOUT;
                    end
                    // Uses next-state shadows so a write on the final cycle counts.
                    verdict_d = exit_verdict(x17_d, x10_d);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            verdict_q <= VERDICT_UNKNOWN;
            x10_q     <= '0;
            x17_q     <= '0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            verdict_q <= verdict_d;
            x10_q     <= x10_d;
            x17_q     <= x17_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    asrv32_trace_fifo #(
        .WIDTH (RF_TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_rf_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rf_push),
        .pop      (i_rf_pop),
        .din      ({i_rf_rd_addr, i_rf_rd_data}),
        .dout     (o_rf_trace),
        .valid    (o_rf_trace_valid),
        .full     (unused_rf_full),
        .overflow (o_rf_overflow)
    );

    asrv32_trace_fifo #(
        .WIDTH (MEM_TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_mem_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (mem_push),
        .pop      (i_mem_pop),
        .din      ({i_mem_mask, i_mem_addr, i_mem_data}),
        .dout     (o_mem_trace),
        .valid    (o_mem_trace_valid),
        .full     (unused_mem_full),
        .overflow (o_mem_overflow)
    );

    assign o_state         = state_q;
    assign o_done          = (state_q == ST_DONE);
    assign o_cause         = cause_q;
    assign o_verdict       = verdict_q;
    assign o_exit_code     = {1'b0, x10_q[31:1]};
    assign o_cycle_count   = cycle_q;
    assign o_retired_count = retired_q;

endmodule

// File: tb/tb_asrv32_test_monitor.sv
module tb_asrv32_test_monitor;

    localparam int unsigned MEMD = 2000;
    localparam int unsigned TMO  = 50;
    localparam int unsigned TD   = 4;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_run = 1'b0;
    logic [31:0] i_inst = '0;
    logic        i_inst_valid = 1'b0;
    logic [31:0] i_iaddr = '0;
    logic        i_rf_wr_en = 1'b0;
    logic [4:0]  i_rf_rd_addr = '0;
    logic [31:0] i_rf_rd_data = '0;
    logic        i_mem_wr_en = 1'b0;
    logic [31:0] i_mem_addr = '0;
    logic [31:0] i_mem_data = '0;
    logic [3:0]  i_mem_mask = '0;
    logic        i_rf_pop = 1'b0;
    logic        i_mem_pop = 1'b0;

    logic        o_rf_trace_valid, o_mem_trace_valid;
    logic [36:0] o_rf_trace;
    logic [67:0] o_mem_trace;
    logic        o_rf_overflow, o_mem_overflow;
    logic [1:0]  o_state, o_cause, o_verdict;
    logic        o_done;
    logic [31:0] o_exit_code, o_cycle_count, o_retired_count;

    asrv32_test_monitor #(
        .MEMORY_DEPTH   (MEMD),
        .TIMEOUT_CYCLES (TMO),
        .TRACE_DEPTH    (TD),
        .CNT_W          (32)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_run             (i_run),
        .i_inst            (i_inst),
        .i_inst_valid      (i_inst_valid),
        .i_iaddr           (i_iaddr),
        .i_rf_wr_en        (i_rf_wr_en),
        .i_rf_rd_addr      (i_rf_rd_addr),
        .i_rf_rd_data      (i_rf_rd_data),
        .i_mem_wr_en       (i_mem_wr_en),
        .i_mem_addr        (i_mem_addr),
        .i_mem_data        (i_mem_data),
        .i_mem_mask        (i_mem_mask),
        .i_rf_pop          (i_rf_pop),
        .i_mem_pop         (i_mem_pop),
        .o_rf_trace_valid  (o_rf_trace_valid),
        .o_mem_trace_valid (o_mem_trace_valid),
        .o_rf_trace        (o_rf_trace),
        .o_mem_trace       (o_mem_trace),
        .o_rf_overflow     (o_rf_overflow),
        .o_mem_overflow    (o_mem_overflow),
        .o_state           (o_state),
        .o_done            (o_done),
        .o_cause           (o_cause),
        .o_verdict         (o_verdict),
        .o_exit_code       (o_exit_code),
        .o_cycle_count     (o_cycle_count),
        .o_retired_count   (o_retired_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: 0 idle, 1 running, 2 finished.
    int          m_state = 0;
    int          m_cause = 0;
    int          m_verdict = 0;
    logic [31:0] m_x10 = '0;
    logic [31:0] m_x17 = '0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ret = '0;
    bit          m_rf_ovf = 1'b0;
    bit          m_mem_ovf = 1'b0;
    logic [36:0] m_rfq[$];
    logic [67:0] m_memq[$];

    task automatic model_step();
        bit tmo;
        if (!rst_n) begin
            m_state = 0; m_cause = 0; m_verdict = 0;
            m_x10 = '0; m_x17 = '0; m_cyc = '0; m_ret = '0;
            m_rf_ovf = 0; m_mem_ovf = 0;
            m_rfq.delete(); m_memq.delete();
            return;
        end
        if (i_rf_pop && m_rfq.size() > 0) void'(m_rfq.pop_front());
        if (i_mem_pop && m_memq.size() > 0) void'(m_memq.pop_front());
        if (m_state == 0) begin
            if (i_run) m_state = 1;
        end else if (m_state == 1) begin
            if (i_rf_wr_en && i_rf_rd_addr != 0) begin
                if (m_rfq.size() < TD) m_rfq.push_back({i_rf_rd_addr, i_rf_rd_data});
                else m_rf_ovf = 1;
            end
            if (i_mem_wr_en) begin
                if (m_memq.size() < TD) m_memq.push_back({i_mem_mask, i_mem_addr, i_mem_data});
                else m_mem_ovf = 1;
            end
            tmo = (m_cyc == TMO - 1);
            if (m_cyc != 32'hffff_ffff) m_cyc = m_cyc + 1;
            if (i_inst_valid && m_ret != 32'hffff_ffff) m_ret = m_ret + 1;
            if (i_rf_wr_en && i_rf_rd_addr == 10) m_x10 = i_rf_rd_data;
            if (i_rf_wr_en && i_rf_rd_addr == 17) m_x17 = i_rf_rd_data;
            if (i_inst_valid && i_inst == EBRK) m_cause = 1;
            else if (i_inst_valid && i_iaddr >= MEMD - 4) m_cause = 2;
            else if (tmo) m_cause = 3;
            if (m_cause != 0) begin
                m_state = 2;
                if (m_x17 == 32'h5d) m_verdict = (m_x10 == 0) ? 1 : 2;
                else m_verdict = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state", o_state, m_state);
            check("done", o_done, m_state == 2);
            check("cause", o_cause, m_cause);
            check("verdict", o_verdict, m_verdict);
            check("exit_code", o_exit_code, m_x10 >> 1);
            check("cycle_count", o_cycle_count, m_cyc);
            check("retired_count", o_retired_count, m_ret);
            check("rf_valid", o_rf_trace_valid, m_rfq.size() > 0);
            check("mem_valid", o_mem_trace_valid, m_memq.size() > 0);
            check("rf_trace", o_rf_trace, (m_rfq.size() > 0) ? m_rfq[0] : 37'd0);
            check("mem_trace", o_mem_trace, (m_memq.size() > 0) ? m_memq[0] : 68'd0);
            check("rf_overflow", o_rf_overflow, m_rf_ovf);
            check("mem_overflow", o_mem_overflow, m_mem_ovf);
        end
    end

    // Advance one cycle; strobes fall back to idle after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
        i_inst_valid = 0; i_rf_wr_en = 0; i_mem_wr_en = 0;
        i_rf_pop = 0; i_mem_pop = 0;
    endtask

    task automatic rf_wr(input logic [4:0] rd, input logic [31:0] d);
        i_rf_wr_en = 1; i_rf_rd_addr = rd; i_rf_rd_data = d;
    endtask

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
        i_mem_wr_en = 1; i_mem_addr = a; i_mem_data = d; i_mem_mask = 4'hf;
    endtask

    task automatic retire(input logic [31:0] inst, input logic [31:0] addr);
        i_inst_valid = 1; i_inst = inst; i_iaddr = addr;
    endtask

    task automatic do_reset();
        rst_n = 0;
        i_run = 0;
        i_inst_valid = 0; i_rf_wr_en = 0; i_mem_wr_en = 0; i_rf_pop = 0; i_mem_pop = 0;
        #2;
        check("rst_state", o_state, 2'd0);
        check("rst_rf_valid", o_rf_trace_valid, 1'b0);
        check("rst_mem_valid", o_mem_trace_valid, 1'b0);
        check("rst_cycle", o_cycle_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        cmp_en = 1;
    endtask

    task automatic start_run();
        i_run = 1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Pass flow: x17=0x5d, x10=0, then ebreak.
        do_reset();
        start_run();
        rf_wr(17, 32'h5d); tick();
        rf_wr(10, 32'h0); tick();
        retire(EBRK, 32'h100); tick();
        check("t1_state", o_state, 2'd2);
        check("t1_cause", o_cause, 2'd1);
        check("t1_verdict", o_verdict, 2'd1);
        check("t1_model_verdict", m_verdict, 1);
        check("t1_exit", o_exit_code, 32'd0);
        check("t1_cycles", o_cycle_count, 32'd3);
        check("t1_retired", o_retired_count, 32'd1);
        check("t1_rf_head", o_rf_trace, {5'd17, 32'h5d});
        i_rf_pop = 1; tick();
        check("t1_rf_head2", o_rf_trace, {5'd10, 32'h0});

        // Fail flow: x10=6 written in the ebreak cycle, with a memory write.
        do_reset();
        start_run();
        rf_wr(17, 32'h5d); tick();
        rf_wr(10, 32'd6); mem_wr(32'h40, 32'habcd); retire(EBRK, 32'h104); tick();
        check("t2_verdict", o_verdict, 2'd2);
        check("t2_exit", o_exit_code, 32'd3);
        check("t2_mem_head", o_mem_trace, {4'hf, 32'h40, 32'habcd});
        i_rf_pop = 1; tick();
        check("t2_rf_head", o_rf_trace, {5'd10, 32'd6});

        // Timeout after exactly TMO run cycles.
        do_reset();
        start_run();
        repeat (TMO - 1) tick();
        check("t3_still_run", o_state, 2'd1);
        tick();
        check("t3_state", o_state, 2'd2);
        check("t3_cycles", o_cycle_count, 32'd50);
        check("t3_cause", o_cause, 2'd3);
        check("t3_verdict", o_verdict, 2'd0);
        retire(32'h13, 32'h0); tick();
        check("t3_frozen", o_cycle_count, 32'd50);

        // Address limit; x0 writes and post-DONE writes are not traced.
        do_reset();
        start_run();
        retire(32'h13, 32'h7c8); tick();
        rf_wr(0, 32'h123); tick();
        check("t4_x0", o_rf_trace_valid, 1'b0);
        check("t4_run", o_state, 2'd1);
        retire(32'h13, 32'h7cc); tick();
        check("t4_cause", o_cause, 2'd2);
        rf_wr(5, 32'h9); mem_wr(32'h8, 32'h1); tick();
        check("t4_rf_after", o_rf_trace_valid, 1'b0);
        check("t4_mem_after", o_mem_trace_valid, 1'b0);

        // Overflow, ordering, push+pop while full, then reset mid-run.
        do_reset();
        start_run();
        for (int i = 0; i < 6; i++) begin
            mem_wr(32'(4 * i), 32'(i + 1)); tick();
        end
        check("t5_mem_ovf", o_mem_overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t5_mem_order", o_mem_trace[31:0], 32'(i + 1));
            i_mem_pop = 1; tick();
        end
        check("t5_mem_empty", o_mem_trace_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rf_wr(5'(i + 1), 32'h100 + 32'(i)); tick();
        end
        rf_wr(5'd5, 32'h104); i_rf_pop = 1; tick();
        check("t5_rf_ovf", o_rf_overflow, 1'b0);
        check("t5_rf_head", o_rf_trace, {5'd2, 32'h101});
        mem_wr(32'h10, 32'h77); tick();
        mem_wr(32'h14, 32'h78); tick();
        rst_n = 0;
        #1;
        check("t6_state", o_state, 2'd0);
        check("t6_rf_valid", o_rf_trace_valid, 1'b0);
        check("t6_mem_valid", o_mem_trace_valid, 1'b0);
        check("t6_rf_trace", o_rf_trace, 37'd0);
        check("t6_cycles", o_cycle_count, 32'd0);
        check("t6_ovf", o_mem_overflow, 1'b0);

        // Random episodes against the model.
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            n = $urandom_range(0, 3);
            for (int c = 0; c < n; c++) begin
                rf_wr(5'($urandom), $urandom); mem_wr($urandom, $urandom);
                retire(EBRK, 32'h0); tick();
            end
            i_run = 1;
            n = $urandom_range(10, 70);
            for (int c = 0; c < n; c++) begin
                i_run = 1'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    n = n;
                    retire(($urandom_range(0, 24) == 0) ? EBRK : $urandom,
                           ($urandom_range(0, 29) == 0) ? 32'($urandom_range(1994, 2003))
                                                        : 32'($urandom_range(0, 1990)));
                end
                if ($urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0: i_rf_rd_addr = 5'd0;
                        1: i_rf_rd_addr = 5'd10;
                        2: i_rf_rd_addr = 5'd17;
                        default: i_rf_rd_addr = 5'($urandom);
                    endcase
                    case ($urandom_range(0, 2))
                        0: i_rf_rd_data = 32'h0;
                        1: i_rf_rd_data = 32'h5d;
                        default: i_rf_rd_data = $urandom;
                    endcase
                    i_rf_wr_en = 1;
                end
                if ($urandom_range(0, 9) < 4) begin
                    i_mem_wr_en = 1; i_mem_addr = $urandom; i_mem_data = $urandom;
                    i_mem_mask = 4'($urandom);
                end
                i_rf_pop = ($urandom_range(0, 9) < 3);
                i_mem_pop = ($urandom_range(0, 9) < 3);
                tick();
            end
        end

        @(posedge clk);
        #1;
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
